// File: rtl/serial_receive_buffer_pkg.sv
// Shared definitions for the serial receive buffer: receiver FSM encoding,
// CPU register map and status register bit layout.
package serial_receive_buffer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_e;

  localparam logic ADDR_DATA   = 1'b0;
  localparam logic ADDR_STATUS = 1'b1;

  localparam int STAT_NOT_EMPTY = 0;
  localparam int STAT_FULL      = 1;
  localparam int STAT_OVERRUN   = 2;
  localparam int STAT_FRAMING   = 3;
  localparam int STAT_IRQ_EN    = 7;

  function automatic logic [7:0] pack_status(input logic irq_enable,
                                             input logic framing_error,
                                             input logic overrun,
                                             input logic full,
                                             input logic not_empty);
    return {irq_enable, 3'b000, framing_error, overrun, full, not_empty};
  endfunction

endpackage

// File: rtl/serial_receive_buffer_sync_fifo.sv
// Single-clock FIFO with occupancy count; a push into a full FIFO is only
// accepted when a pop happens on the same edge.
module sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [WIDTH-1:0]      wdata,
  output logic [WIDTH-1:0]      rdata,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  do_push_s;
  logic                  do_pop_s;

  assign full      = (count_q == DEPTH_CNT);
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign rdata     = mem_q[rd_ptr_q];
  assign do_pop_s  = pop & ~empty;
  assign do_push_s = push & (~full | do_pop_s);

  // Next-state for pointers and occupancy
  always_comb begin
    wr_ptr_d = do_push_s ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop_s  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/serial_receive_buffer.sv
// 8N1 serial receiver feeding a byte FIFO, with a two-register CPU port
// (data / status-control) and a level interrupt request.
module serial_receive_buffer
  import serial_receive_buffer_pkg::*;
#(
  parameter int CLOCK_DIVISOR   = 434,
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  input  logic       en,
  input  logic       wr,
  input  logic       addr,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       ready
);

  localparam int CNT_W = (CLOCK_DIVISOR > 2) ? $clog2(CLOCK_DIVISOR) : 1;
  localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(CLOCK_DIVISOR / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(CLOCK_DIVISOR - 1);

  logic [1:0]             sync_q;
  logic                   rxd_s;
  rx_state_e              state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [2:0]             bit_idx_q;
  logic [7:0]             shift_q;

  logic                   irq_enable_q, irq_enable_d;
  logic                   framing_q, framing_d;
  logic                   overrun_q, overrun_d;

  logic                   expire_s;
  logic                   rx_push_s;
  logic                   rx_frame_err_s;
  logic                   pop_s;
  logic                   status_wr_s;
  logic                   fifo_full_s;
  logic                   fifo_empty_s;
  logic                   not_empty_s;
  logic [7:0]             fifo_rdata_s;
  logic [FIFO_DEPTH_LOG2:0] fifo_count_s;

  // Two-flop synchronizer, idles high so reset never looks like a start bit
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], rxd};
    end
  end

  assign rxd_s          = sync_q[1];
  assign expire_s       = (cnt_q == '0);
  assign rx_push_s      = (state_q == ST_STOP) && expire_s && rxd_s;
  assign rx_frame_err_s = (state_q == ST_STOP) && expire_s && !rxd_s;

  // Receiver FSM: half-bit wait centres all later samples in their bit cells
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!rxd_s) begin
            state_q <= ST_START;
            cnt_q   <= HALF_BIT;
          end
        end
        ST_START: begin
          if (expire_s) begin
            if (!rxd_s) begin
              state_q   <= ST_DATA;
              cnt_q     <= FULL_BIT;
              bit_idx_q <= 3'd0;
            end else begin
              state_q <= ST_IDLE;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_DATA: begin
          if (expire_s) begin
            shift_q <= {rxd_s, shift_q[7:1]};
            cnt_q   <= FULL_BIT;
            if (bit_idx_q == 3'd7) begin
              state_q <= ST_STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_STOP: begin
          if (expire_s) begin
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign pop_s       = en & ~wr & (addr == ADDR_DATA) & ~fifo_empty_s;
  assign status_wr_s = en & wr & (addr == ADDR_STATUS);
  assign not_empty_s = (fifo_count_s != '0);

  sync_fifo #(
    .WIDTH      (8),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (rx_push_s),
    .pop   (pop_s),
    .wdata (shift_q),
    .rdata (fifo_rdata_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (fifo_count_s)
  );

  // Sticky flags: a new event in the same cycle as a write-1-clear wins
  always_comb begin
    irq_enable_d = status_wr_s ? data_in[STAT_IRQ_EN] : irq_enable_q;
    framing_d    = (framing_q & ~(status_wr_s & data_in[STAT_FRAMING])) | rx_frame_err_s;
    overrun_d    = (overrun_q & ~(status_wr_s & data_in[STAT_OVERRUN]))
                 | (rx_push_s & fifo_full_s & ~pop_s);
  end

  // Control/status registers
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_enable_q <= 1'b1;
      framing_q    <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      irq_enable_q <= irq_enable_d;
      framing_q    <= framing_d;
      overrun_q    <= overrun_d;
    end
  end

  assign ready = not_empty_s & irq_enable_q;

  // CPU read mux
  always_comb begin
    case (addr)
      ADDR_DATA:   data_out = fifo_empty_s ? 8'h00 : fifo_rdata_s;
      ADDR_STATUS: data_out = pack_status(irq_enable_q, framing_q, overrun_q,
                                          fifo_full_s, not_empty_s);
      default:     data_out = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_serial_receive_buffer.sv
// Directed bench for serial_receive_buffer with a byte scoreboard and a small
// flag model; DUT runs with 16 clocks per bit and a 4-entry FIFO.
module tb_serial_receive_buffer;

  localparam int DIV   = 16;
  localparam int DEPTH = 4;

  logic       clk;
  logic       reset;
  logic       rxd;
  logic       en;
  logic       wr;
  logic       addr;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       ready;

  int         checks;
  int         errors;
  logic [7:0] exp_q[$];
  logic       m_irq;
  logic       m_fr;
  logic       m_ovr;
  logic [7:0] rd;

  serial_receive_buffer #(
    .CLOCK_DIVISOR   (DIV),
    .FIFO_DEPTH_LOG2 (2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rxd      (rxd),
    .en       (en),
    .wr       (wr),
    .addr     (addr),
    .data_in  (data_in),
    .data_out (data_out),
    .ready    (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_status();
    return {m_irq, 3'b000, m_fr, m_ovr, exp_q.size() == DEPTH, exp_q.size() != 0};
  endfunction

  task automatic cpu_read(input logic a, output logic [7:0] d);
    @(negedge clk);
    en = 1'b1; wr = 1'b0; addr = a;
    #1 d = data_out;
    @(posedge clk);
    #1 en = 1'b0;
  endtask

  task automatic cpu_write(input logic a, input logic [7:0] v);
    @(negedge clk);
    en = 1'b1; wr = 1'b1; addr = a; data_in = v;
    @(posedge clk);
    #1 en = 1'b0; wr = 1'b0;
    if (a == 1'b1) begin
      m_irq = v[7];
      if (v[3]) m_fr = 1'b0;
      if (v[2]) m_ovr = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(negedge clk);
    rxd = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (DIV) @(negedge clk);
    end
    rxd = stop;
    repeat (DIV) @(negedge clk);
    rxd = 1'b1;
    repeat (20) @(negedge clk);
    if (!stop) m_fr = 1'b1;
    else if (exp_q.size() < DEPTH) exp_q.push_back(b);
    else m_ovr = 1'b1;
  endtask

  task automatic check_status(input string tag);
    logic [7:0] d;
    cpu_read(1'b1, d);
    check(tag, d, exp_status());
  endtask

  task automatic check_pop(input string tag);
    logic [7:0] d;
    logic [7:0] e;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
    cpu_read(1'b0, d);
    check(tag, d, e);
  endtask

  task automatic check_ready(input string tag);
    @(negedge clk);
    #1 check(tag, {7'd0, ready}, {7'd0, m_irq & (exp_q.size() != 0)});
  endtask

  initial begin
    checks = 0; errors = 0;
    rxd = 1'b1; en = 1'b0; wr = 1'b0; addr = 1'b0; data_in = 8'h00;
    m_irq = 1'b1; m_fr = 1'b0; m_ovr = 1'b0;
    reset = 1'b1;
    repeat (5) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    check_ready("rst_ready");
    cpu_read(1'b0, rd);
    check("rst_data", rd, 8'h00);
    cpu_read(1'b1, rd);
    check("rst_status", rd, 8'h80);

    // Single byte
    send_byte(8'hA5, 1'b1);
    check_ready("a5_ready");
    check_status("a5_status");
    check_pop("a5_data");
    check_status("a5_status_after");
    check_ready("a5_ready_after");

    // Overfill: fifth byte dropped
    for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b1);
    check_status("ovr_status");
    cpu_read(1'b1, rd);
    check("ovr_status_abs", rd, 8'h87);
    for (int i = 0; i < 5; i++) check_pop("ovr_data");
    check_status("ovr_status_drained");
    cpu_write(1'b1, 8'h84);
    check_status("ovr_cleared");

    // Framing error
    send_byte(8'h3F, 1'b0);
    check_status("fr_status");
    cpu_write(1'b1, 8'h88);
    check_status("fr_cleared");

    // Short low glitch
    @(negedge clk);
    rxd = 1'b0;
    repeat (4) @(negedge clk);
    rxd = 1'b1;
    repeat (40) @(negedge clk);
    check_status("glitch_status");
    check_ready("glitch_ready");

    // Interrupt enable gating
    cpu_write(1'b1, 8'h00);
    send_byte(8'h3C, 1'b1);
    check_ready("irqoff_ready");
    check_status("irqoff_status");
    cpu_write(1'b1, 8'h80);
    check_ready("irqon_ready");
    check_pop("irqon_data");

    // Reset in the middle of a frame
    @(negedge clk);
    rxd = 1'b0;
    repeat (DIV) @(negedge clk);
    rxd = 1'b0; repeat (DIV) @(negedge clk);
    rxd = 1'b1; repeat (DIV) @(negedge clk);
    rxd = 1'b0; repeat (DIV / 2) @(negedge clk);
    reset = 1'b1;
    rxd = 1'b1;
    repeat (20) @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    m_irq = 1'b1; m_fr = 1'b0; m_ovr = 1'b0;
    repeat (20) @(negedge clk);
    check_status("midrst_status");
    send_byte(8'h5A, 1'b1);
    check_status("midrst_rx_status");
    check_pop("midrst_rx_data");
    check_status("final_status");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
